// File: rtl/stack_lifo.sv
// LIFO stack over a single-port synchronous-read RAM.
// A push takes one cycle; a pop to a non-empty stack reloads the new top in a POP_RD cycle.
module stack_lifo #(
    parameter int RAM_WIDTH     = 17,
    parameter int RAM_ADDR_BITS = 14
) (
    input  logic                     clka,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [RAM_WIDTH-1:0]     din,
    output logic                     ready,
    output logic [RAM_WIDTH-1:0]     dout,
    output logic                     dout_valid,
    output logic                     empty,
    output logic                     full,
    output logic [RAM_ADDR_BITS:0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    // state  | meaning
    // IDLE   | accepting push/pop, ready=1
    // POP_RD | RAM addressed at the new top, dout reloads at end of cycle
    typedef enum logic {IDLE, POP_RD} state_t;

    localparam int DEPTH = 2 ** RAM_ADDR_BITS;
    localparam logic [RAM_ADDR_BITS:0] DEPTH_C = {1'b1, {RAM_ADDR_BITS{1'b0}}};

    state_t state, state_nxt;

    logic [RAM_WIDTH-1:0]     mem [DEPTH];
    logic [RAM_WIDTH-1:0]     rd_data;
    logic [RAM_WIDTH-1:0]     dout_reg;
    logic                     dout_sel;
    logic [RAM_ADDR_BITS-1:0] top_addr;
    logic [RAM_ADDR_BITS-1:0] ram_addr;
    logic                     ram_we;
    logic                     ram_re;
    logic                     accept;
    logic                     do_push;
    logic                     do_replace;
    logic                     do_pop;
    logic                     do_ovf;
    logic                     do_unf;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    // Wraps correctly at count == DEPTH because the low bits are then zero.
    assign top_addr = count[RAM_ADDR_BITS-1:0] - 1'b1;
    assign dout     = dout_sel ? rd_data : dout_reg;

    always_ff @(posedge clka) begin
        if (reset || clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (do_pop && (count != {{RAM_ADDR_BITS{1'b0}}, 1'b1})) state_nxt = POP_RD;
            POP_RD:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready      = (state == IDLE);
        accept     = ready && !clear && !reset;
        do_replace = accept && push && pop && !empty;
        do_push    = accept && push && !(pop && !empty) && !full;
        do_ovf     = accept && push && !pop && full;
        do_pop     = accept && pop && !push && !empty;
        do_unf     = accept && pop && !push && empty;
        ram_we     = do_push || do_replace;
        ram_re     = (state == POP_RD) && !clear && !reset;
        ram_addr   = (do_replace || (state == POP_RD)) ? top_addr : count[RAM_ADDR_BITS-1:0];
    end

    // Storage is never reset so it maps onto block RAM.
    always_ff @(posedge clka) begin
        if (ram_we) begin
            mem[ram_addr] <= din;
        end
        if (ram_re) begin
            rd_data <= mem[ram_addr];
        end
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            count      <= '0;
            dout_reg   <= '0;
            dout_sel   <= 1'b0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            count      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (state == POP_RD) begin
            dout_sel   <= 1'b1;
            dout_valid <= 1'b1;
        end else begin
            if (do_push || do_replace) begin
                dout_reg   <= din;
                dout_sel   <= 1'b0;
                dout_valid <= 1'b1;
            end
            if (do_push) begin
                count <= count + 1'b1;
            end
            if (do_pop) begin
                count      <= count - 1'b1;
                dout_valid <= 1'b0;
            end
            if (do_ovf) begin
                overflow <= 1'b1;
            end
            if (do_unf) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_lifo.sv
// Self-checking bench for stack_lifo: scoreboard of expected dout words plus a stack model.
module tb_stack_lifo;

    localparam int W      = 17;
    localparam int AB     = 2;
    localparam int DEPTH  = 4;
    localparam int BAB    = 14;
    localparam int BDEPTH = 16384;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic          reset, push, pop, clear;
    logic [W-1:0]  din;
    logic          ready, dout_valid, empty, full, overflow, underflow;
    logic [W-1:0]  dout;
    logic [AB:0]   count;

    logic          b_reset, b_push, b_pop, b_clear;
    logic [W-1:0]  b_din;
    logic          b_ready, b_dout_valid, b_empty, b_full, b_overflow, b_underflow;
    logic [W-1:0]  b_dout;
    logic [BAB:0]  b_count;

    stack_lifo #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) u_dut (
        .clka(clka), .reset(reset), .push(push), .pop(pop), .clear(clear), .din(din),
        .ready(ready), .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    stack_lifo #(.RAM_WIDTH(W), .RAM_ADDR_BITS(BAB)) u_big (
        .clka(clka), .reset(b_reset), .push(b_push), .pop(b_pop), .clear(b_clear), .din(b_din),
        .ready(b_ready), .dout(b_dout), .dout_valid(b_dout_valid), .empty(b_empty), .full(b_full),
        .count(b_count), .overflow(b_overflow), .underflow(b_underflow)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] mdl[$];
    logic [W-1:0] exp_q[$];
    bit           m_ov, m_un, m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic chk_state(input string tag);
        logic [W-1:0] e;
        chk({tag, "_count"}, 32'(count), mdl.size());
        chk({tag, "_empty"}, 32'(empty), (mdl.size() == 0) ? 1 : 0);
        chk({tag, "_full"}, 32'(full), (mdl.size() == DEPTH) ? 1 : 0);
        chk({tag, "_ready"}, 32'(ready), 1);
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ov));
        chk({tag, "_unf"}, 32'(underflow), 32'(m_un));
        chk({tag, "_valid"}, 32'(dout_valid), 32'(m_valid));
        if (m_valid) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = mdl[mdl.size()-1];
            chk({tag, "_dout"}, 32'(dout), 32'(e));
        end
    endtask

    task automatic op(input string tag, input bit p, input bit q, input logic [W-1:0] d);
        push = p; pop = q; din = d;
        step();
        push = 1'b0; pop = 1'b0;
        if (p && (!q || mdl.size() == 0)) begin
            if (mdl.size() < DEPTH) begin
                mdl.push_back(d);
                exp_q.push_back(d);
                m_valid = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end else if (p && q) begin
            mdl[mdl.size()-1] = d;
            exp_q.push_back(d);
            m_valid = 1'b1;
        end else if (q) begin
            if (mdl.size() == 0) begin
                m_un = 1'b1;
            end else begin
                void'(mdl.pop_back());
                if (mdl.size() > 0) begin
                    chk({tag, "_busy_ready"}, 32'(ready), 0);
                    chk({tag, "_busy_valid"}, 32'(dout_valid), 0);
                    push = 1'b1; pop = 1'b1;
                    step();
                    push = 1'b0; pop = 1'b0;
                    exp_q.push_back(mdl[mdl.size()-1]);
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        chk_state(tag);
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1; push = 1'b1; din = 17'h15555;
        step();
        clear = 1'b0; push = 1'b0;
        mdl.delete();
        exp_q.delete();
        m_ov = 1'b0; m_un = 1'b0; m_valid = 1'b0;
        chk_state(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_dout"}, 32'(dout), 0);
        chk({tag, "_valid"}, 32'(dout_valid), 0);
        chk({tag, "_ready"}, 32'(ready), 1);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_unf"}, 32'(underflow), 0);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0; din = '0;
        b_reset = 1'b1; b_push = 1'b0; b_pop = 1'b0; b_clear = 1'b0; b_din = '0;
        m_ov = 1'b0; m_un = 1'b0; m_valid = 1'b0;
        step();
        step();
        chk_reset_vals("rst");
        reset = 1'b0; b_reset = 1'b0;

        // Three pushes, then pop back down to empty
        op("push1", 1, 0, 17'h00011);
        op("push2", 1, 0, 17'h00022);
        op("push3", 1, 0, 17'h00033);
        op("pop1", 0, 1, '0);
        op("pop2", 0, 1, '0);
        op("pop3", 0, 1, '0);

        // Fill, overflow, clear
        op("fill1", 1, 0, 17'h0AAAA);
        op("fill2", 1, 0, 17'h05555);
        op("fill3", 1, 0, 17'h1234F);
        op("fill4", 1, 0, 17'h1C001);
        op("ovf", 1, 0, 17'h1FFFF);
        op("full_repl", 1, 1, 17'h00777);
        do_clear("clr1");

        // Underflow stickiness and replace-top
        op("unf", 0, 1, '0);
        op("pp_empty", 1, 1, 17'h00003);
        op("unf_push", 1, 0, 17'h00005);
        op("repl", 1, 1, 17'h0000A);
        op("pop_after_repl", 0, 1, '0);
        do_clear("clr2");

        // Reset while the pop read is in flight, with clear and push also asserted
        op("pre1", 1, 0, 17'h00001);
        op("pre2", 1, 0, 17'h00002);
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("poprd_ready", 32'(ready), 0);
        reset = 1'b1; clear = 1'b1; push = 1'b1; din = 17'h1EEEE;
        step();
        reset = 1'b0; clear = 1'b0; push = 1'b0;
        chk_reset_vals("rst_poprd");
        step();
        chk("rst_poprd_hold_dout", 32'(dout), 0);
        mdl.delete(); exp_q.delete();
        m_ov = 1'b0; m_un = 1'b0; m_valid = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            int  r;
            bit  p, q;
            r = $urandom_range(0, 11);
            if (r == 0) begin
                do_clear("rnd_clr");
            end else begin
                p = 1'($urandom_range(0, 1));
                q = 1'($urandom_range(0, 1));
                if (!p && !q) p = 1'b1;
                op("rnd", p, q, W'($urandom()));
            end
        end

        // Deep instance: fill all 16384 entries
        b_push = 1'b1;
        for (int i = 0; i < BDEPTH; i++) begin
            b_din = W'(i);
            step();
        end
        b_push = 1'b0;
        chk("big_full", 32'(b_full), 1);
        chk("big_count", 32'(b_count), BDEPTH);
        chk("big_dout", 32'(b_dout), BDEPTH - 1);
        chk("big_ovf0", 32'(b_overflow), 0);
        b_push = 1'b1; b_din = 17'h1FFFF;
        step();
        b_push = 1'b0;
        chk("big_ovf", 32'(b_overflow), 1);
        chk("big_count_ovf", 32'(b_count), BDEPTH);
        b_pop = 1'b1;
        step();
        b_pop = 1'b0;
        step();
        chk("big_pop_valid", 32'(b_dout_valid), 1);
        chk("big_pop_dout", 32'(b_dout), BDEPTH - 2);
        chk("big_pop_count", 32'(b_count), BDEPTH - 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
